// File: rtl/adder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_pkg : op encodings, default geometry and 4-bit P/G group helper
// Rev 1.0
// ----------------------------------------------------------------------------
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ADD_WIDTH_DEF = 32;
  localparam int ADD_SEG_W_DEF = 16;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] g;
    logic       gp;
    logic       gg;
  } grp_pg_t;

  function automatic grp_pg_t grp_pg(input logic [3:0] a, input logic [3:0] b);
    grp_pg_t r;
    r.p  = a ^ b;
    r.g  = a & b;
    r.gp = &r.p;
    r.gg = r.g[3] | (r.p[3] & r.g[2]) | (r.p[3] & r.p[2] & r.g[1]) |
           (r.p[3] & r.p[2] & r.p[1] & r.g[0]);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_seg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cla_seg : SEG_W-bit combinational two-level carry-lookahead adder
// Rev 1.0
// ----------------------------------------------------------------------------
module cla_seg
  import adder_pkg::*;
#(
  parameter int SEG_W = ADD_SEG_W_DEF
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb
);

  localparam int NG = SEG_W / 4;

  grp_pg_t          grp [NG];
  logic [NG:0]      cg;
  logic [SEG_W-1:0] c;

  always_comb begin
    for (int j = 0; j < NG; j++) begin
      grp[j] = grp_pg(a[4*j +: 4], b[4*j +: 4]);
    end
  end

  // Group carries as flat sum-of-products over group P/G
  always_comb begin
    logic t;
    t  = 1'b0;
    cg = '0;
    for (int j = 0; j <= NG; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t = t & grp[m].gp;
      cg[j] = t;
      for (int i = 0; i < j; i++) begin
        t = grp[i].gg;
        for (int m = i + 1; m < j; m++) t = t & grp[m].gp;
        cg[j] = cg[j] | t;
      end
    end
  end

  always_comb begin
    logic t;
    t = 1'b0;
    c = '0;
    s = '0;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        t = cg[j];
        for (int m = 0; m < i; m++) t = t & grp[j].p[m];
        c[4*j+i] = t;
        for (int k = 0; k < i; k++) begin
          t = grp[j].g[k];
          for (int m = k + 1; m < i; m++) t = t & grp[j].p[m];
          c[4*j+i] = c[4*j+i] | t;
        end
        s[4*j+i] = grp[j].p[i] ^ c[4*j+i];
      end
    end
  end

  assign co    = cg[NG];
  assign c_msb = c[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe_cla.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_pipe_cla : segment-pipelined lookahead add/sub with valid/ready flow
// Rev 1.0
// ----------------------------------------------------------------------------
module adder_pipe_cla
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF,
  parameter int SEG_W = ADD_SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0 || (SEG_W % 4) != 0 || WIDTH < 16 || WIDTH > 128) begin : g_param_err
    $error("adder_pipe_cla: illegal WIDTH/SEG_W combination");
  end

  logic en;

  // Stage-k inputs: index 0 is the port side, index k>0 is stage k-1's register
  logic [NSEG-1:0]            stg_v;
  logic [NSEG-1:0]            stg_sub;
  logic [NSEG-1:0]            stg_c;
  logic [NSEG-1:0][WIDTH-1:0] stg_a;
  logic [NSEG-1:0][WIDTH-1:0] stg_b;
  logic [NSEG-1:0][WIDTH-1:0] stg_s;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  assign stg_v[0]   = in_valid;
  assign stg_sub[0] = sub;
  assign stg_c[0]   = (sub == OP_SUB) ? 1'b1 : cin;
  assign stg_a[0]   = a;
  assign stg_b[0]   = b;
  assign stg_s[0]   = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG_W;

    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_s;
    logic             seg_co;
    logic             seg_cm;
    logic [WIDTH-1:0] sum_d;

    assign seg_b = stg_sub[k] ? ~stg_b[k][LO +: SEG_W] : stg_b[k][LO +: SEG_W];

    cla_seg #(.SEG_W(SEG_W)) u_seg (
      .a     (stg_a[k][LO +: SEG_W]),
      .b     (seg_b),
      .ci    (stg_c[k]),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cm)
    );

    always_comb begin
      sum_d             = stg_s[k];
      sum_d[LO +: SEG_W] = seg_s;
    end

    if (k < NSEG - 1) begin : g_mid
      logic             v_q;
      logic             sub_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             unused_cm;

      assign unused_cm = seg_cm;

      // Payload only loads behind a valid beat; bubbles leave it untouched
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
        end else if (en) begin
          v_q <= stg_v[k];
          if (stg_v[k]) begin
            sub_q <= stg_sub[k];
            c_q   <= seg_co;
            a_q   <= stg_a[k];
            b_q   <= stg_b[k];
            s_q   <= sum_d;
          end
        end
      end

      assign stg_v[k+1]   = v_q;
      assign stg_sub[k+1] = sub_q;
      assign stg_c[k+1]   = c_q;
      assign stg_a[k+1]   = a_q;
      assign stg_b[k+1]   = b_q;
      assign stg_s[k+1]   = s_q;
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
        end else if (en) begin
          out_valid_q <= stg_v[k];
          if (stg_v[k]) begin
            sum_q  <= sum_d;
            cout_q <= seg_co;
            ovf_q  <= seg_co ^ seg_cm;
            zero_q <= ~|sum_d;
          end
        end
      end
    end
  end

  logic unused_ops;
  assign unused_ops = ^{stg_a[NSEG-1], stg_b[NSEG-1]};

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_cla.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adder_pipe_cla : runs WIDTH 16/32/64 instances side by side against a model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_adder_pipe_cla;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam int WID [3] = '{16, 32, 64};
  localparam int LAT [3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;

  logic [2:0]  ir, ov, co_o, of_o, zr_o;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;

  int errors = 0;
  int checks = 0;

  exp_t fifo [3][64];
  int   wp [3] = '{0, 0, 0};
  int   rp [3] = '{0, 0, 0};
  int   rx_cnt [3] = '{0, 0, 0};
  exp_t held [3];
  logic hold_v [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  adder_pipe_cla #(.WIDTH(16), .SEG_W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s16),
    .cout(co_o[0]), .ovf(of_o[0]), .zero(zr_o[0])
  );

  adder_pipe_cla #(.WIDTH(32), .SEG_W(16)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s32),
    .cout(co_o[1]), .ovf(of_o[1]), .zero(zr_o[1])
  );

  adder_pipe_cla #(.WIDTH(64), .SEG_W(16)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(s64),
    .cout(co_o[2]), .ovf(of_o[2]), .zero(zr_o[2])
  );

  // Reference: plain wide arithmetic, overflow from operand/result sign rules
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    logic [64:0] full;
    logic [63:0] mask, aa, bb, r;
    exp_t e;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & mask;
    bb   = (sb ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
    r    = full[63:0] & mask;
    e.sum  = r;
    e.cout = full[w];
    if (sb) e.ovf = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
    else    e.ovf = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    e.zero = (r == 64'd0);
    return e;
  endfunction

  function automatic exp_t get_out(input int d);
    case (d)
      0:       return {48'd0, s16, co_o[0], of_o[0], zr_o[0]};
      1:       return {32'd0, s32, co_o[1], of_o[1], zr_o[1]};
      default: return {s64, co_o[2], of_o[2], zr_o[2]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        wp[d]     = 0;
        rp[d]     = 0;
        hold_v[d] = 1'b0;
      end else begin
        chk($sformatf("in_ready_w%0d", WID[d]), {67'd0, ir[d]}, {67'd0, (~ov[d] | out_ready)});
        if (hold_v[d])
          chk($sformatf("stall_hold_w%0d", WID[d]), {ov[d], get_out(d)}, {1'b1, held[d]});
        hold_v[d] = ov[d] && !out_ready;
        held[d]   = get_out(d);
        if (ov[d] && out_ready) begin
          if (wp[d] == rp[d]) begin
            chk($sformatf("spurious_out_valid_w%0d", WID[d]), {67'd0, ov[d]}, 68'd0);
          end else begin
            chk($sformatf("result_w%0d", WID[d]), {1'b0, get_out(d)}, {1'b0, fifo[d][rp[d] % 64]});
            rp[d]++;
            rx_cnt[d]++;
          end
        end
        if (in_valid && ir[d]) begin
          fifo[d][wp[d] % 64] = model(WID[d], a_in, b_in, cin, sub);
          wp[d]++;
        end
      end
    end
  end

  // One beat with out_ready high; checks latency and hand-computed result
  task automatic run_vec(input int d, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic sb, input logic [63:0] es,
                         input logic ec, input logic eo, input logic ez);
    int   n;
    exp_t lit;
    lit = {es, ec, eo, ez};
    chk($sformatf("model_pin_w%0d", WID[d]), {1'b0, model(WID[d], a, b, ci, sb)}, {1'b0, lit});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in = a; b_in = b; cin = ci; sub = sb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!ov[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency_w%0d", WID[d]), 68'(n), 68'(LAT[d]));
    chk($sformatf("directed_w%0d", WID[d]), {1'b0, get_out(d)}, {1'b0, lit});
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int base [3];

    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ov_w%0d", WID[d]), {67'd0, ov[d]}, 68'd0);
      chk($sformatf("reset_out_w%0d", WID[d]), {1'b0, get_out(d)}, 68'd0);
      chk($sformatf("reset_ready_w%0d", WID[d]), {67'd0, ir[d]}, 68'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WIDTH=32
    run_vec(1, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    run_vec(1, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_vec(1, 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_vec(1, 64'h7FFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0);
    // WIDTH=16
    run_vec(0, 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    run_vec(0, 64'h8000, 64'h1, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0);
    run_vec(0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1'b0);
    // WIDTH=64
    run_vec(2, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_vec(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    run_vec(2, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_vec(2, 64'd5, 64'd5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream
    for (int d = 0; d < 3; d++) base[d] = rx_cnt[d];
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("stream_count_w%0d", WID[d]), 68'(rx_cnt[d] - base[d]), 68'd100);
      chk($sformatf("stream_drain_w%0d", WID[d]), 68'(wp[d]), 68'(rp[d]));
    end

    // Random valid / ready
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("random_drain_w%0d", WID[d]), 68'(wp[d]), 68'(rp[d]));

    // Reset with beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_in = 64'h1234_5678_9ABC_DEF0 + 64'(i);
      b_in = 64'h0FED_CBA9_8765_4321;
      cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_rst_ov_w%0d", WID[d]), {67'd0, ov[d]}, 68'd0);
      chk($sformatf("async_rst_out_w%0d", WID[d]), {1'b0, get_out(d)}, 68'd0);
      chk($sformatf("async_rst_ready_w%0d", WID[d]), {67'd0, ir[d]}, 68'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("post_rst_idle_w%0d", WID[d]), {67'd0, ov[d]}, 68'd0);
    run_vec(2, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
